true_dp_ram_be: RTL and testbench

TRUE_DP_RAM_BE -- requirements
Module: true_dp_ram_be

---
 rtl/true_dp_ram_be.sv | 161 ++++++++++++++++
 tb/tb_true_dp_ram_be.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/true_dp_ram_be.sv
// True dual-port RAM with per-byte write enables, a single shared clock,
// selectable write-port read behaviour and an optional output register.
//
// Read strobe: every accepted read (and every write in READ_FIRST or
// WRITE_FIRST mode) produces exactly one val pulse, one edge later with
// OUT_REG=0 or two edges later with OUT_REG=1. dout holds its last value
// whenever val is low. There is no back-pressure, so a result is never stalled.
module true_dp_ram_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_WIDTH = 8,
    parameter int WRITE_MODE = 0,   // 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
    parameter int OUT_REG    = 0    // 1 adds a second output stage
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ena,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   wea,
    input  logic [ADDR_WIDTH-1:0]              addra,
    input  logic [DATA_WIDTH-1:0]              dina,
    input  logic                               enb,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   web,
    input  logic [ADDR_WIDTH-1:0]              addrb,
    input  logic [DATA_WIDTH-1:0]              dinb,
    output logic [DATA_WIDTH-1:0]              douta,
    output logic                               vala,
    output logic [DATA_WIDTH-1:0]              doutb,
    output logic                               valb,
    output logic                               collision
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Lane width must tile the word exactly.
    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_lane_width
        $error("true_dp_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    // Storage is deliberately never reset so it can map onto block RAM.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;

    logic [DATA_WIDTH-1:0] douta1_d, douta1_q, douta2_d, douta2_q;
    logic [DATA_WIDTH-1:0] doutb1_d, doutb1_q, doutb2_d, doutb2_q;
    logic                  vala1_d, vala1_q, vala2_d, vala2_q;
    logic                  valb1_d, valb1_q, valb2_d, valb2_q;
    logic                  collision_d, collision_q;

    // Pre-write contents at each port's address.
    assign rd_a = mem[addra];
    assign rd_b = mem[addrb];

    // Replace only the lanes selected by we; other lanes keep the old word.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NB-1:0]         we
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++) begin
            if (we[i]) begin
                r[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return r;
    endfunction

    // Stage-1 result per port: what the accepted operation returns, if anything.
    always_comb begin
        douta1_d = douta1_q;
        vala1_d  = 1'b0;
        if (ena) begin
            if ((wea == '0) || (WRITE_MODE == 0)) begin
                douta1_d = rd_a;
                vala1_d  = 1'b1;
            end else if (WRITE_MODE == 1) begin
                douta1_d = merge_lanes(rd_a, dina, wea);
                vala1_d  = 1'b1;
            end
        end

        doutb1_d = doutb1_q;
        valb1_d  = 1'b0;
        if (enb) begin
            if ((web == '0) || (WRITE_MODE == 0)) begin
                doutb1_d = rd_b;
                valb1_d  = 1'b1;
            end else if (WRITE_MODE == 1) begin
                doutb1_d = merge_lanes(rd_b, dinb, web);
                valb1_d  = 1'b1;
            end
        end
    end

    // Stage-2 output register captures only real results; val just follows stage 1.
    always_comb begin
        douta2_d = vala1_q ? douta1_q : douta2_q;
        vala2_d  = vala1_q;
        doutb2_d = valb1_q ? doutb1_q : doutb2_q;
        valb2_d  = valb1_q;
    end

    // Same-address access with at least one writer.
    always_comb begin
        collision_d = ena && enb && (addra == addrb) && ((wea != '0) || (web != '0));
    end

    // Output pipeline and collision flag; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            douta1_q    <= '0;
            vala1_q     <= 1'b0;
            douta2_q    <= '0;
            vala2_q     <= 1'b0;
            doutb1_q    <= '0;
            valb1_q     <= 1'b0;
            doutb2_q    <= '0;
            valb2_q     <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            douta1_q    <= douta1_d;
            vala1_q     <= vala1_d;
            douta2_q    <= douta2_d;
            vala2_q     <= vala2_d;
            doutb1_q    <= doutb1_d;
            valb1_q     <= valb1_d;
            doutb2_q    <= doutb2_d;
            valb2_q     <= valb2_d;
            collision_q <= collision_d;
        end
    end

    // Array writes: B lanes first, then A lanes, so A wins any lane both write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // contents are preserved; nothing is written while in reset
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (enb && web[i]) begin
                    mem[addrb][i*BYTE_WIDTH +: BYTE_WIDTH] <= dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
            for (int i = 0; i < NB; i++) begin
                if (ena && wea[i]) begin
                    mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    assign douta     = (OUT_REG != 0) ? douta2_q : douta1_q;
    assign vala      = (OUT_REG != 0) ? vala2_q  : vala1_q;
    assign doutb     = (OUT_REG != 0) ? doutb2_q : doutb1_q;
    assign valb      = (OUT_REG != 0) ? valb2_q  : valb1_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_true_dp_ram_be.sv
// Bench for true_dp_ram_be: twelve instances (3 write modes x 2 output-register
// settings x {ADDR_WIDTH 10, ADDR_WIDTH 4}) share one set of port inputs.
// Directed vectors target instance 0; a reference model follows all twelve.
module tb_true_dp_ram_be;

    localparam int NI = 12;

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ena, enb;
    logic [3:0]  wea, web;
    logic [9:0]  addra, addrb;
    logic [31:0] dina, dinb;

    logic [31:0] douta_w [NI];
    logic [31:0] doutb_w [NI];
    logic        vala_w  [NI];
    logic        valb_w  [NI];
    logic        coll_w  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int AW = (g < 6) ? 10 : 4;
        true_dp_ram_be #(
            .DATA_WIDTH (32),
            .ADDR_WIDTH (AW),
            .BYTE_WIDTH (8),
            .WRITE_MODE (g % 3),
            .OUT_REG    ((g / 3) % 2)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .ena       (ena),
            .wea       (wea),
            .addra     (addra[AW-1:0]),
            .dina      (dina),
            .enb       (enb),
            .web       (web),
            .addrb     (addrb[AW-1:0]),
            .dinb      (dinb),
            .douta     (douta_w[g]),
            .vala      (vala_w[g]),
            .doutb     (doutb_w[g]),
            .valb      (valb_w[g]),
            .collision (coll_w[g])
        );
    end

    // Scoreboard counters
    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mm    [NI][1024];
    bit          m_pv  [NI][2];
    logic [31:0] m_pd  [NI][2];
    bit          m_sv  [NI][2];
    logic [31:0] m_sd  [NI][2];
    bit          m_col [NI];

    function automatic logic [31:0] lane_mask(input logic [3:0] we);
        return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction

    // What an operation on one port returns (has=0: nothing returned).
    task automatic port_result(input int wm, input logic en, input logic [3:0] we,
                               input logic [31:0] old_w, input logic [31:0] din,
                               output bit has, output logic [31:0] d);
        has = 1'b0;
        d   = 32'h0;
        if (en) begin
            if (we == 4'h0 || wm == 0) begin
                has = 1'b1;
                d   = old_w;
            end else if (wm == 1) begin
                has = 1'b1;
                d   = (old_w & ~lane_mask(we)) | (din & lane_mask(we));
            end
        end
    endtask

    // A result becomes visible after 1 edge, or after 2 edges with the output register.
    task automatic show(input int g, input int p, input int orr, input bit has, input logic [31:0] d);
        if (orr == 0) begin
            m_sv[g][p] = has;
            if (has) m_sd[g][p] = d;
        end else begin
            m_sv[g][p] = m_pv[g][p];
            if (m_pv[g][p]) m_sd[g][p] = m_pd[g][p];
            m_pv[g][p] = has;
            m_pd[g][p] = d;
        end
    endtask

    task automatic model_step(input int g);
        int          am, wm, orr, ia, ib;
        logic [31:0] olda, oldb, ra, rb;
        bit          ha, hb;
        am  = (g < 6) ? 1023 : 15;
        wm  = g % 3;
        orr = (g / 3) % 2;
        ia  = int'(addra) & am;
        ib  = int'(addrb) & am;
        olda = mm[g][ia];
        oldb = mm[g][ib];
        port_result(wm, ena, wea, olda, dina, ha, ra);
        port_result(wm, enb, web, oldb, dinb, hb, rb);
        show(g, 0, orr, ha, ra);
        show(g, 1, orr, hb, rb);
        m_col[g] = ena && enb && (ia == ib) && (wea != 4'h0 || web != 4'h0);
        if (enb) begin
            logic [3:0] wb_eff;
            wb_eff = (ena && ia == ib) ? (web & ~wea) : web;
            mm[g][ib] = (mm[g][ib] & ~lane_mask(wb_eff)) | (dinb & lane_mask(wb_eff));
        end
        if (ena) mm[g][ia] = (mm[g][ia] & ~lane_mask(wea)) | (dina & lane_mask(wea));
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < NI; g++) begin
                for (int p = 0; p < 2; p++) begin
                    m_pv[g][p] = 1'b0;
                    m_pd[g][p] = 32'h0;
                    m_sv[g][p] = 1'b0;
                    m_sd[g][p] = 32'h0;
                end
                m_col[g] = 1'b0;
            end
        end else begin
            for (int g = 0; g < NI; g++) model_step(g);
        end
    end

    // Compare every instance against the model each cycle, away from the edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < NI; g++) begin
                chk($sformatf("mdl g%0d douta", g), douta_w[g], m_sd[g][0]);
                chk($sformatf("mdl g%0d vala", g), {31'b0, vala_w[g]}, {31'b0, m_sv[g][0]});
                chk($sformatf("mdl g%0d doutb", g), doutb_w[g], m_sd[g][1]);
                chk($sformatf("mdl g%0d valb", g), {31'b0, valb_w[g]}, {31'b0, m_sv[g][1]});
                chk($sformatf("mdl g%0d collision", g), {31'b0, coll_w[g]}, {31'b0, m_col[g]});
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drv(input logic ea, input logic [3:0] wa, input logic [9:0] aa, input logic [31:0] da,
                       input logic eb, input logic [3:0] wb, input logic [9:0] ab, input logic [31:0] db);
        ena = ea; wea = wa; addra = aa; dina = da;
        enb = eb; web = wb; addrb = ab; dinb = db;
    endtask

    task automatic idle();
        drv(1'b0, 4'h0, 10'h0, 32'h0, 1'b0, 4'h0, 10'h0, 32'h0);
    endtask

    typedef struct {
        logic        ea;
        logic [3:0]  wa;
        logic [9:0]  aa;
        logic [31:0] da;
        logic        eb;
        logic [3:0]  wb;
        logic [9:0]  ab;
        logic [31:0] db;
        logic [31:0] xda;
        logic        xva;
        logic [31:0] xdb;
        logic        xvb;
        logic        xcol;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic ea, input logic [3:0] wa, input logic [9:0] aa, input logic [31:0] da,
                                input logic eb, input logic [3:0] wb, input logic [9:0] ab, input logic [31:0] db,
                                input logic [31:0] xda, input logic xva, input logic [31:0] xdb, input logic xvb,
                                input logic xcol);
        vec_t v;
        v.ea = ea; v.wa = wa; v.aa = aa; v.da = da;
        v.eb = eb; v.wb = wb; v.ab = ab; v.db = db;
        v.xda = xda; v.xva = xva; v.xdb = xdb; v.xvb = xvb; v.xcol = xcol;
        return v;
    endfunction

    initial begin
        // Expected results for instance 0 (READ_FIRST, latency 1, 1024 words).
        // Every word starts as 0xC0DE0000 | address from the fill pass.
        tbl[0]  = mk(1'b1, 4'hF, 10'h005, 32'hDEADBEEF, 1'b0, 4'h0, 10'h000, 32'h0,
                     32'hC0DE0005, 1'b1, 32'h00000000, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 4'h0, 10'h000, 32'h0, 1'b1, 4'h0, 10'h005, 32'h0,
                     32'hC0DE0005, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
        tbl[2]  = mk(1'b1, 4'hF, 10'h010, 32'h11223344, 1'b0, 4'h0, 10'h000, 32'h0,
                     32'hC0DE0010, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        tbl[3]  = mk(1'b1, 4'h5, 10'h010, 32'hAABBCCDD, 1'b0, 4'h0, 10'h000, 32'h0,
                     32'h11223344, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        tbl[4]  = mk(1'b1, 4'h0, 10'h010, 32'h0, 1'b0, 4'h0, 10'h000, 32'h0,
                     32'h11BB33DD, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        tbl[5]  = mk(1'b1, 4'hF, 10'h020, 32'hAAAAAAAA, 1'b1, 4'h3, 10'h020, 32'h55555555,
                     32'hC0DE0020, 1'b1, 32'hC0DE0020, 1'b1, 1'b1);
        tbl[6]  = mk(1'b1, 4'h0, 10'h020, 32'h0, 1'b0, 4'h0, 10'h000, 32'h0,
                     32'hAAAAAAAA, 1'b1, 32'hC0DE0020, 1'b0, 1'b0);
        tbl[7]  = mk(1'b1, 4'hC, 10'h020, 32'h00000000, 1'b1, 4'h3, 10'h020, 32'hFFFFFFFF,
                     32'hAAAAAAAA, 1'b1, 32'hAAAAAAAA, 1'b1, 1'b1);
        tbl[8]  = mk(1'b0, 4'h0, 10'h000, 32'h0, 1'b1, 4'h0, 10'h020, 32'h0,
                     32'hAAAAAAAA, 1'b0, 32'h0000FFFF, 1'b1, 1'b0);
        tbl[9]  = mk(1'b1, 4'hF, 10'h030, 32'h00000001, 1'b0, 4'h0, 10'h000, 32'h0,
                     32'hC0DE0030, 1'b1, 32'h0000FFFF, 1'b0, 1'b0);
        tbl[10] = mk(1'b1, 4'hF, 10'h030, 32'h00000002, 1'b1, 4'h0, 10'h030, 32'h0,
                     32'h00000001, 1'b1, 32'h00000001, 1'b1, 1'b1);
        tbl[11] = mk(1'b0, 4'h0, 10'h000, 32'h0, 1'b1, 4'h0, 10'h030, 32'h0,
                     32'h00000001, 1'b0, 32'h00000002, 1'b1, 1'b0);
        tbl[12] = mk(1'b1, 4'h0, 10'h030, 32'h0, 1'b1, 4'h0, 10'h030, 32'h0,
                     32'h00000002, 1'b1, 32'h00000002, 1'b1, 1'b0);
        tbl[13] = mk(1'b1, 4'h0, 10'h3FF, 32'h0, 1'b1, 4'hF, 10'h3FF, 32'h12345678,
                     32'hC0DE03FF, 1'b1, 32'hC0DE03FF, 1'b1, 1'b1);
        tbl[14] = mk(1'b1, 4'h0, 10'h3FF, 32'h0, 1'b1, 4'h0, 10'h000, 32'h0,
                     32'h12345678, 1'b1, 32'hC0DE0000, 1'b1, 1'b0);

        // Reset state
        idle();
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("rst g%0d douta", g), douta_w[g], 32'h0);
            chk($sformatf("rst g%0d vala", g), {31'b0, vala_w[g]}, 32'h0);
            chk($sformatf("rst g%0d collision", g), {31'b0, coll_w[g]}, 32'h0);
        end
        #1;

        // Fill every word with a known pattern: A even addresses, B odd.
        rst = 1'b0;
        for (int k = 0; k < 512; k++) begin
            drv(1'b1, 4'hF, 10'(2*k),   32'hC0DE0000 | 32'(2*k),
                1'b1, 4'hF, 10'(2*k+1), 32'hC0DE0000 | 32'(2*k+1));
            @(negedge clk);
            #1;
        end

        // Asynchronous reset clears outputs immediately; contents survive.
        idle();
        rst = 1'b1;
        #1;
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("arst g%0d douta", g), douta_w[g], 32'h0);
            chk($sformatf("arst g%0d doutb", g), doutb_w[g], 32'h0);
            chk($sformatf("arst g%0d valb", g), {31'b0, valb_w[g]}, 32'h0);
        end
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;

        // Directed vectors; the first is applied together with reset release.
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            drv(tbl[i].ea, tbl[i].wa, tbl[i].aa, tbl[i].da, tbl[i].eb, tbl[i].wb, tbl[i].ab, tbl[i].db);
            @(negedge clk);
            chk($sformatf("vec%0d douta", i), douta_w[0], tbl[i].xda);
            chk($sformatf("vec%0d vala", i), {31'b0, vala_w[0]}, {31'b0, tbl[i].xva});
            chk($sformatf("vec%0d doutb", i), doutb_w[0], tbl[i].xdb);
            chk($sformatf("vec%0d valb", i), {31'b0, valb_w[0]}, {31'b0, tbl[i].xvb});
            chk($sformatf("vec%0d collision", i), {31'b0, coll_w[0]}, {31'b0, tbl[i].xcol});
            #1;
        end

        // Byte-lane write seen through each write mode and both latencies.
        drv(1'b1, 4'hF, 10'h010, 32'h11223344, 1'b0, 4'h0, 10'h0, 32'h0);
        @(negedge clk); #1;
        drv(1'b1, 4'h5, 10'h010, 32'hAABBCCDD, 1'b0, 4'h0, 10'h0, 32'h0);
        @(negedge clk);
        chk("lane rf douta", douta_w[0], 32'h11223344);
        chk("lane wf douta", douta_w[1], 32'h11BB33DD);
        chk("lane wf vala", {31'b0, vala_w[1]}, 32'h1);
        chk("lane nc douta", douta_w[2], 32'h12345678);
        chk("lane nc vala", {31'b0, vala_w[2]}, 32'h0);
        #1;
        idle();
        @(negedge clk);
        chk("lane rf2 douta", douta_w[3], 32'h11223344);
        chk("lane wf2 douta", douta_w[4], 32'h11BB33DD);
        chk("lane wf2 vala", {31'b0, vala_w[4]}, 32'h1);
        chk("lane nc2 vala", {31'b0, vala_w[5]}, 32'h0);
        #1;
        drv(1'b0, 4'h0, 10'h0, 32'h0, 1'b1, 4'h0, 10'h010, 32'h0);
        @(negedge clk);
        chk("rdb lat1 doutb", doutb_w[0], 32'h11BB33DD);
        chk("rdb lat2 early valb", {31'b0, valb_w[3]}, 32'h0);
        #1;
        idle();
        @(negedge clk);
        chk("rdb lat2 doutb", doutb_w[3], 32'h11BB33DD);
        chk("rdb lat2 valb", {31'b0, valb_w[3]}, 32'h1);
        #1;

        // Reset between the two edges of a latency-2 read.
        drv(1'b1, 4'h0, 10'h005, 32'h0, 1'b0, 4'h0, 10'h0, 32'h0);
        @(negedge clk); #1;
        idle();
        rst = 1'b1;
        #1;
        chk("midrst douta", douta_w[3], 32'h0);
        chk("midrst vala", {31'b0, vala_w[3]}, 32'h0);
        @(negedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst no pulse", {31'b0, vala_w[3]}, 32'h0);
            #1;
        end
        drv(1'b1, 4'h0, 10'h005, 32'h0, 1'b0, 4'h0, 10'h0, 32'h0);
        @(negedge clk); #1;
        idle();
        @(negedge clk);
        chk("postrst douta", douta_w[3], 32'hDEADBEEF);
        chk("postrst vala", {31'b0, vala_w[3]}, 32'h1);
        #1;

        // Random dual-port traffic; addresses 0..31 alias in the 16-word instances.
        for (int n = 0; n < 3000; n++) begin
            drv(1'($urandom_range(0, 3) != 0),
                ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                10'($urandom_range(0, 31)), $urandom,
                1'($urandom_range(0, 3) != 0),
                ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                10'($urandom_range(0, 31)), $urandom);
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            #1;
        end
        rst = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
